// File: rtl/board_stimulus_sequencer_pkg.sv
// Shared definitions for the stimulus sequencer: FSM states, the released-key
// level and the width of the packed step word {delay, key, switch}.
package board_stimulus_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_FINISH = 2'd2
    } seq_state_t;

    // Keys are active-low, so a released key reads as 1.
    localparam logic KEY_RELEASED = 1'b1;

    function automatic int step_word_w(input int delay_w, input int keys, input int switches);
        return delay_w + keys + switches;
    endfunction

endpackage

// File: rtl/board_stimulus_sequencer_step_ram.sv
// Step table: one {delay, key, switch} word per step, synchronous write,
// combinational read, contents survive reset.
module stimulus_step_ram
    import board_stimulus_sequencer_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int WORD_W = 30
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/board_stimulus_sequencer.sv
// Plays a programmed table of KEY/SW patterns, each held for a per-step cycle
// count, with one-shot/loop modes, abort and a global cycle budget.
module board_stimulus_sequencer
    import board_stimulus_sequencer_pkg::*;
#(
    parameter int NUM_KEYS      = 4,
    parameter int NUM_SWITCHES  = 10,
    parameter int NUM_STEPS     = 8,
    parameter int DELAY_WIDTH   = 16,
    parameter int TIMEOUT_WIDTH = 24,
    localparam int AW           = $clog2(NUM_STEPS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     prog_we,
    input  logic [AW-1:0]            prog_addr,
    input  logic [DELAY_WIDTH-1:0]   prog_delay,
    input  logic [NUM_KEYS-1:0]      prog_key,
    input  logic [NUM_SWITCHES-1:0]  prog_switch,
    input  logic [AW:0]              step_count,
    input  logic                     loop_mode,
    input  logic [TIMEOUT_WIDTH-1:0] timeout,
    input  logic                     start,
    input  logic                     abort,
    output logic [NUM_KEYS-1:0]      key_out,
    output logic [NUM_SWITCHES-1:0]  switch_out,
    output logic                     busy,
    output logic                     done,
    output logic                     timed_out,
    output logic [AW-1:0]            step_index
);

    localparam int WORD_W = step_word_w(DELAY_WIDTH, NUM_KEYS, NUM_SWITCHES);

    seq_state_t               state, state_nx;
    logic [AW:0]              n_steps;
    logic                     loop_r;
    logic [TIMEOUT_WIDTH-1:0] tmo_limit, tmo_cnt;
    logic [DELAY_WIDTH-1:0]   hold_cnt;
    logic [NUM_SWITCHES-1:0]  sw_last;

    logic [WORD_W-1:0]        rd_word;
    logic [DELAY_WIDTH-1:0]   rd_delay;
    logic [NUM_KEYS-1:0]      rd_key;
    logic [NUM_SWITCHES-1:0]  rd_sw;
    logic                     tbl_we, start_ok, step_end, last_step, tmo_hit;

    // The table is frozen while playing so the combinational read stays stable.
    assign tbl_we = prog_we && (state != ST_PLAY)
                 && ({1'b0, prog_addr} < (AW+1)'(NUM_STEPS));

    stimulus_step_ram #(
        .DEPTH  (NUM_STEPS),
        .AW     (AW),
        .WORD_W (WORD_W)
    ) u_step_ram (
        .clock (clock),
        .we    (tbl_we),
        .waddr (prog_addr),
        .wdata ({prog_delay, prog_key, prog_switch}),
        .raddr (step_index),
        .rdata (rd_word)
    );

    assign {rd_delay, rd_key, rd_sw} = rd_word;

    assign start_ok  = start && (step_count != '0) && (step_count <= (AW+1)'(NUM_STEPS));
    // Hold counter counts up from 0; a delay of 0 behaves like 1.
    assign step_end  = (rd_delay <= DELAY_WIDTH'(1)) || (hold_cnt == rd_delay - DELAY_WIDTH'(1));
    assign last_step = ({1'b0, step_index} == n_steps - (AW+1)'(1));
    assign tmo_hit   = (tmo_limit != '0) && (tmo_cnt == tmo_limit - TIMEOUT_WIDTH'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        busy       = 1'b0;
        done       = 1'b0;
        timed_out  = 1'b0;
        key_out    = {NUM_KEYS{KEY_RELEASED}};
        switch_out = sw_last;
        unique case (state)
            ST_IDLE: begin
                if (start_ok) state_nx = ST_PLAY;
            end
            ST_PLAY: begin
                busy       = 1'b1;
                key_out    = rd_key;
                switch_out = rd_sw;
                // Abort outranks both the budget and the final step.
                timed_out  = tmo_hit && !abort;
                if (abort || tmo_hit) begin
                    state_nx = ST_IDLE;
                end else if (step_end && last_step && !loop_r) begin
                    state_nx = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step_index <= '0;
            n_steps    <= '0;
            loop_r     <= 1'b0;
            tmo_limit  <= '0;
            tmo_cnt    <= '0;
            hold_cnt   <= '0;
            sw_last    <= '0;
        end else if (state == ST_IDLE) begin
            if (start_ok) begin
                step_index <= '0;
                hold_cnt   <= '0;
                tmo_cnt    <= '0;
                n_steps    <= step_count;
                loop_r     <= loop_mode;
                tmo_limit  <= timeout;
            end
        end else if (state == ST_PLAY) begin
            sw_last <= rd_sw;
            tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
            if (abort || tmo_hit) begin
                step_index <= '0;
                hold_cnt   <= '0;
            end else if (step_end) begin
                hold_cnt   <= '0;
                step_index <= last_step ? '0 : step_index + AW'(1);
            end else begin
                hold_cnt <= hold_cnt + DELAY_WIDTH'(1);
            end
        end
    end

endmodule
